arith_ram_sequencer: RTL
========================

// Module: arith_ram_sequencer
// PURPOSE
// Arithmetic-side driver of the dual-port operand RAM (port B: addr_arith/we_arith/data_arith/q_arith).
// On start, walks COUNT element pairs: reads X[base_x+i], Y[base_y+i], hands them to the multiplier
// via valid/ready, takes the result and writes it to Z[base_z+i]. Reports busy/done and a cycle count
// so the HPS can measure arithmetic throughput after reading results back over Avalon.
// PARAMETERS
// PORT_WIDTH  32  data width of RAM port B, operands and result
// ADDR_WIDTH  11  RAM address width (2048 words)
// RD_LAT      2   cycles from addr_arith register update to q_arith valid for capture
// PORTS
// ram_clock   in   1           single clock; must be the same clock as the RAM's port B
// reset       in   1           synchronous, active-high
// start       in   1           1-cycle pulse; accepted only in IDLE
// count       in   ADDR_WIDTH  number of elements; 0 = immediate done
// base_x      in   ADDR_WIDTH  X vector base address
// base_y      in   ADDR_WIDTH  Y vector base address
// base_z      in   ADDR_WIDTH  result base address
// busy        out  1           high from the cycle after start is accepted until done
// done        out  1           1-cycle pulse at completion
// cycles      out  32          ram_clock cycles spent busy in the last run; held until next start
// addr_arith  out  ADDR_WIDTH  RAM port B address (registered)
// we_arith    out  1           RAM port B write enable (registered)
// data_arith  out  PORT_WIDTH  RAM port B write data (registered)
// q_arith     in   PORT_WIDTH  RAM port B read data
// op_x, op_y  out  PORT_WIDTH  operands to arithmetic unit; stable while op_valid && !op_ready
// op_valid    out  1           operand pair valid
// op_ready    in   1           arithmetic unit accepts pair when op_valid && op_ready
// res_data    in   PORT_WIDTH  result from arithmetic unit
// res_valid   in   1           result valid
// res_ready   out  1           high only in WAIT_RES; transfer when res_valid && res_ready
// BEHAVIOUR
// - Reset: state IDLE; busy, done, op_valid, res_ready, we_arith = 0; addr_arith, data_arith,
//   op_x, op_y, index = 0; cycles = 0. Reset mid-run abandons the run: no further RAM write occurs.
// - FSM: IDLE -start&&count!=0-> RD_X -> WAIT_X (RD_LAT-1 cycles, capture q_arith into op_x)
//   -> RD_Y -> WAIT_Y (capture into op_y) -> ISSUE -(op_valid&&op_ready)-> WAIT_RES
//   -(res_valid)-> WRITE -> (index==count-1 ? FINISH : RD_X, index+1) ; FINISH -> IDLE.
// - start with count==0: done pulses next cycle, busy stays 0, cycles = 0, no RAM access.
// - start while busy is ignored; count/base_* are latched at acceptance, later changes ignored.
// - Addresses: base+index, modulo 2^ADDR_WIDTH (wrap 2047 -> 0, no error).
// - WRITE: we_arith=1 for exactly one cycle, addr_arith=base_z+index, data_arith=captured result;
//   we_arith=0 in every other state. Result registered at the res handshake, not held from input.
// - Read capture happens exactly RD_LAT cycles after the RD_x cycle sets addr_arith.
// - op_valid rises on ISSUE entry, drops the cycle after handshake; op_x/op_y never change while valid.
// - res_valid outside WAIT_RES is ignored (res_ready=0). One pair in flight at a time.
// - Z overlapping X/Y is legal: element i is read before element i is written.
// - cycles: cleared on accepted start, +1 each busy cycle, frozen when done pulses.
// - done and busy: busy falls in the same cycle done is high.
// STRUCTURE
// - Shared package arith_seq_pkg: state enum (IDLE,RD_X,WAIT_X,RD_Y,WAIT_Y,ISSUE,WAIT_RES,WRITE,
//   FINISH), ADDR_WIDTH/PORT_WIDTH defaults shared with the RAM wrapper.
// - Single flat module; RD_LAT wait handled by a small down-counter, no sub-module needed.
// TESTING (bench uses true-dual-port RAM model on ram_clock, behavioural multiplier with
//   programmable latency and random op_ready stalls)
// - base_x=0,base_y=16,base_z=32,count=4, X={1,2,3,4},Y={5,6,7,8}, 3-cycle mult -> Z={5,12,21,32}, one done.
// - count=0 start -> done next cycle, busy never 1, no we_arith, cycles=0.
// - base_x=2046,count=4 -> reads 2046,2047,0,1; Z writes wrap likewise.
// - op_ready held low 10 cycles -> op_x/op_y/op_valid stable throughout; res_valid pulsed while
//   in ISSUE -> ignored, no write.
// - start pulsed again while busy -> ignored; reset asserted mid WAIT_RES -> all outputs to reset
//   values, no further Z write, next start runs normally.
// - base_z==base_x, count=3 -> in-place X*Y correct; cycles equals busy-cycle count from bench monitor.

Source files
------------

// File: rtl/arith_seq_pkg.sv
// arith_seq_pkg: shared state encoding and RAM geometry for the arithmetic RAM sequencer
package arith_seq_pkg;
  localparam int DEF_PORT_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 11;
  localparam int DEF_RD_LAT = 2;
  typedef enum logic [3:0] {IDLE, RD_X, WAIT_X, RD_Y, WAIT_Y, ISSUE, WAIT_RES, WRITE, FINISH} state_t;
endpackage

// File: rtl/arith_ram_sequencer.sv
// arith_ram_sequencer: walks X/Y operand pairs from RAM port B through the multiplier and writes Z back
module arith_ram_sequencer
  import arith_seq_pkg::*;
#(
  parameter int PORT_WIDTH = DEF_PORT_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic                  ram_clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] count,
  input  logic [ADDR_WIDTH-1:0] base_x,
  input  logic [ADDR_WIDTH-1:0] base_y,
  input  logic [ADDR_WIDTH-1:0] base_z,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           cycles,
  output logic [ADDR_WIDTH-1:0] addr_arith,
  output logic                  we_arith,
  output logic [PORT_WIDTH-1:0] data_arith,
  input  logic [PORT_WIDTH-1:0] q_arith,
  output logic [PORT_WIDTH-1:0] op_x,
  output logic [PORT_WIDTH-1:0] op_y,
  output logic                  op_valid,
  input  logic                  op_ready,
  input  logic [PORT_WIDTH-1:0] res_data,
  input  logic                  res_valid,
  output logic                  res_ready
);
  localparam int WW = $clog2(RD_LAT) + 1;
  state_t r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_count, r_bx, r_by, r_bz, r_idx;
  logic [WW-1:0] r_wait;
  logic w_last, w_accept;
  assign w_last = r_idx == r_count - ADDR_WIDTH'(1);
  assign w_accept = r_state == IDLE && start;
  always_ff @(posedge ram_clock)
    r_state <= reset ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     if (start) w_next = count == '0 ? FINISH : RD_X;
      RD_X:     w_next = WAIT_X;
      WAIT_X:   if (r_wait == '0) w_next = RD_Y;
      RD_Y:     w_next = WAIT_Y;
      WAIT_Y:   if (r_wait == '0) w_next = ISSUE;
      ISSUE:    if (op_ready) w_next = WAIT_RES;
      WAIT_RES: if (res_valid) w_next = WRITE;
      WRITE:    w_next = w_last ? FINISH : RD_X;
      FINISH:   w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end
  always_comb begin
    busy = !(r_state inside {IDLE, FINISH});
    done = r_state == FINISH;
    res_ready = r_state == WAIT_RES;
  end
  // addr_arith is loaded on entry to RD_X/RD_Y/WRITE, so read capture lands RD_LAT edges later
  always_ff @(posedge ram_clock) begin
    if (reset) begin
      r_count <= '0;
      r_bx <= '0;
      r_by <= '0;
      r_bz <= '0;
      r_idx <= '0;
      r_wait <= '0;
      cycles <= '0;
      addr_arith <= '0;
      we_arith <= 1'b0;
      data_arith <= '0;
      op_x <= '0;
      op_y <= '0;
      op_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_count <= count;
        r_bx <= base_x;
        r_by <= base_y;
        r_bz <= base_z;
        r_idx <= '0;
        cycles <= '0;
      end else if (busy)
        cycles <= cycles + 32'd1;
      if (r_state == WRITE && !w_last)
        r_idx <= r_idx + ADDR_WIDTH'(1);
      if (w_next == RD_X)
        addr_arith <= w_accept ? base_x : r_bx + r_idx + ADDR_WIDTH'(1);
      if (r_state inside {RD_X, RD_Y})
        r_wait <= WW'(RD_LAT - 2);
      else if (r_wait != '0)
        r_wait <= r_wait - WW'(1);
      if (r_state == WAIT_X && w_next == RD_Y) begin
        op_x <= q_arith;
        addr_arith <= r_by + r_idx;
      end
      if (r_state == WAIT_Y && w_next == ISSUE)
        op_y <= q_arith;
      if (r_state == WAIT_RES && res_valid) begin
        data_arith <= res_data;
        addr_arith <= r_bz + r_idx;
      end
      op_valid <= w_next == ISSUE;
      we_arith <= w_next == WRITE;
    end
  end
endmodule
